// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug virtual-JTAG driver: FSM states,
// debug IR codes and default chain geometry.
package nios2_dbg_pkg;

  localparam int DBG_DR_WIDTH = 38;
  localparam int DBG_IR_WIDTH = 2;

  localparam logic [1:0] IR_OCIMEM       = 2'b00;
  localparam logic [1:0] IR_TRACECAPTURE = 2'b01;
  localparam logic [1:0] IR_BREAK        = 2'b10;
  localparam logic [1:0] IR_TRACEMEM     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RESP = 3'd6
  } state_e;

endpackage

// File: rtl/nios2_debug_vjtag_driver_if.sv
// Command/response handshake bundle between a requester (master) and the
// virtual-JTAG driver (slave).
interface nios2_debug_vjtag_driver_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_dr;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_dr;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );

  modport slave (
    input  cmd_valid, cmd_ir, cmd_dr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out
  );
endinterface

// File: rtl/nios2_debug_vjtag_shifter.sv
// DR shift register plus bit counter: parallel load, LSB-first shift with
// serial input at the MSB, and a done flag on the last chain bit.
module nios2_debug_vjtag_shifter #(
  parameter int DR_WIDTH = 38,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_i,
  input  logic [DR_WIDTH-1:0] load_val_i,
  input  logic                shift_i,
  input  logic                serial_i,
  input  logic                cnt_clr_i,
  input  logic                cnt_inc_i,
  output logic [DR_WIDTH-1:0] sh_o,
  output logic [CNT_W-1:0]    cnt_o,
  output logic                done_o
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DR_WIDTH - 1);

  logic [DR_WIDTH-1:0] sh_q;
  logic [CNT_W-1:0]    cnt_q;

  // Shift register: captured bit enters at the MSB so the chain arrives in order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sh_q <= '0;
    end else if (load_i) begin
      sh_q <= load_val_i;
    end else if (shift_i) begin
      sh_q <= {serial_i, sh_q[DR_WIDTH-1:1]};
    end else begin
      sh_q <= sh_q;
    end
  end

  // Bit / idle-cycle counter shared by SDR and RTI.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (cnt_inc_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign sh_o   = sh_q;
  assign cnt_o  = cnt_q;
  assign done_o = (cnt_q == LAST_BIT);

endmodule

// File: rtl/nios2_debug_vjtag_driver.sv
// Host-side virtual-JTAG initiator: runs UIR -> CDR -> SDR x DR_WIDTH -> UDR
// -> RTI for one command and hands back the captured DR chain and IR status.
module nios2_debug_vjtag_driver
  import nios2_dbg_pkg::*;
#(
  parameter int DR_WIDTH   = DBG_DR_WIDTH,
  parameter int IR_WIDTH   = DBG_IR_WIDTH,
  parameter int RTI_CYCLES = 2,
  parameter int CNT_W      = 6
) (
  input  logic                        clk,
  input  logic                        reset_n,
  nios2_debug_vjtag_driver_if.slave   bus,
  output logic [IR_WIDTH-1:0]         ir_in,
  input  logic [IR_WIDTH-1:0]         ir_out,
  output logic                        tdi,
  input  logic                        tdo,
  output logic                        vs_uir,
  output logic                        vs_cdr,
  output logic                        vs_sdr,
  output logic                        vs_udr,
  output logic                        jtag_state_rti
);

  localparam logic [CNT_W-1:0] RTI_LAST =
    CNT_W'((RTI_CYCLES > 0) ? (RTI_CYCLES - 1) : 0);

  state_e              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;

  logic                sh_load;
  logic                sh_shift;
  logic                cnt_clr;
  logic                cnt_inc;
  logic [DR_WIDTH-1:0] sh;
  logic [CNT_W-1:0]    bit_cnt;
  logic                sh_done;

  nios2_debug_vjtag_shifter #(
    .DR_WIDTH (DR_WIDTH),
    .CNT_W    (CNT_W)
  ) u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (sh_load),
    .load_val_i (bus.cmd_dr),
    .shift_i    (sh_shift),
    .serial_i   (tdo),
    .cnt_clr_i  (cnt_clr),
    .cnt_inc_i  (cnt_inc),
    .sh_o       (sh),
    .cnt_o      (bit_cnt),
    .done_o     (sh_done)
  );

  // Sequencer next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    ir_in_d  = ir_in_q;
    rsp_ir_d = rsp_ir_q;
    rsp_dr_d = rsp_dr_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          ir_in_d = bus.cmd_ir;
          sh_load = 1'b1;
          state_d = ST_UIR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UIR: begin
        rsp_ir_d = ir_out;
        state_d  = ST_CDR;
      end
      ST_CDR: begin
        cnt_clr = 1'b1;
        state_d = ST_SDR;
      end
      ST_SDR: begin
        sh_shift = 1'b1;
        cnt_inc  = 1'b1;
        if (sh_done) begin
          state_d = ST_UDR;
        end else begin
          state_d = ST_SDR;
        end
      end
      ST_UDR: begin
        cnt_clr = 1'b1;
        // Zero idle cycles: the chain is already complete, publish it now.
        if (RTI_CYCLES == 0) begin
          rsp_dr_d = sh;
          state_d  = ST_RESP;
        end else begin
          state_d  = ST_RTI;
        end
      end
      ST_RTI: begin
        cnt_inc = 1'b1;
        if (bit_cnt == RTI_LAST) begin
          rsp_dr_d = sh;
          state_d  = ST_RESP;
        end else begin
          state_d  = ST_RTI;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ir_in_q  <= '0;
      rsp_ir_q <= '0;
      rsp_dr_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_in_q  <= ir_in_d;
      rsp_ir_q <= rsp_ir_d;
      rsp_dr_q <= rsp_dr_d;
    end
  end

  assign bus.cmd_ready  = (state_q == ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_dr     = rsp_dr_q;
  assign bus.rsp_ir_out = rsp_ir_q;
  assign ir_in          = ir_in_q;
  assign tdi            = (state_q == ST_SDR) & sh[0];
  assign vs_uir         = (state_q == ST_UIR);
  assign vs_cdr         = (state_q == ST_CDR);
  assign vs_sdr         = (state_q == ST_SDR);
  assign vs_udr         = (state_q == ST_UDR);
  assign jtag_state_rti = (state_q == ST_RTI);

endmodule

// File: tb/tb_nios2_debug_vjtag_driver.sv
// Bench for the virtual-JTAG driver: a behavioural debug-slave chain on the
// far side, phase expectations derived from the access timeline.
module tb_nios2_debug_vjtag_driver;
  import nios2_dbg_pkg::*;

  localparam int DR  = 38;
  localparam int RTI = 2;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  nios2_debug_vjtag_driver_if #(.DR_WIDTH(DR), .IR_WIDTH(2)) bus ();
  nios2_debug_vjtag_driver_if #(.DR_WIDTH(DR), .IR_WIDTH(2)) bus2 ();

  logic [1:0]    ir_in, ir_out, irv_uir, irv_post;
  logic          tdi, tdo, vs_uir, vs_cdr, vs_sdr, vs_udr, rti;
  logic [DR-1:0] sr;
  logic          sl_load;
  logic [DR-1:0] sl_val;

  logic [1:0] ir_in2, ir_out2;
  logic       tdi2, tdo2, vs_uir2, vs_cdr2, vs_sdr2, vs_udr2, rti2;

  nios2_debug_vjtag_driver #(.DR_WIDTH(DR), .IR_WIDTH(2), .RTI_CYCLES(RTI), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .ir_in(ir_in), .ir_out(ir_out), .tdi(tdi), .tdo(tdo),
    .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
    .jtag_state_rti(rti)
  );

  nios2_debug_vjtag_driver #(.DR_WIDTH(DR), .IR_WIDTH(2), .RTI_CYCLES(0), .CNT_W(6)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .ir_in(ir_in2), .ir_out(ir_out2), .tdi(tdi2), .tdo(tdo2),
    .vs_uir(vs_uir2), .vs_cdr(vs_cdr2), .vs_sdr(vs_sdr2), .vs_udr(vs_udr2),
    .jtag_state_rti(rti2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Debug slave model: sr shifts toward bit 0 while in SDR, TDI enters at the top.
  always @(posedge clk) begin
    if (sl_load) sr <= sl_val;
    else if (vs_sdr) sr <= {tdi, sr[DR-1:1]};
  end
  assign tdo     = sr[0];
  assign ir_out  = vs_uir ? irv_uir : irv_post;
  assign ir_out2 = 2'b11;
  assign tdo2    = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {uir,cdr,sdr,udr,rti,rsp_valid} for cycle c after the accept edge.
  function automatic logic [5:0] exp_phase(input int c, input int rti_n);
    logic [5:0] p;
    p = 6'b000000;
    if (c == 1)                 p = 6'b100000;
    else if (c == 2)            p = 6'b010000;
    else if (c < 3 + DR)        p = 6'b001000;
    else if (c == 3 + DR)       p = 6'b000100;
    else if (c < 4 + DR + rti_n) p = 6'b000010;
    else                        p = 6'b000001;
    return p;
  endfunction

  task automatic start_cmd(input logic [1:0] ir, input logic [DR-1:0] dr, input logic [DR-1:0] pre);
    chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'(1'b1));
    sl_load = 1'b1;
    sl_val  = pre;
    bus.cmd_valid = 1'b1;
    bus.cmd_ir    = ir;
    bus.cmd_dr    = dr;
    tick();
    bus.cmd_valid = 1'b0;
    sl_load       = 1'b0;
  endtask

  // Walk cycles 1..first RESP cycle, checking phase, ir_in, tdi and slave chain.
  task automatic run_seq(input logic [1:0] ir, input logic [DR-1:0] dr,
                         input logic [DR-1:0] pre, input logic [1:0] iru);
    for (int c = 1; c <= 4 + DR + RTI; c++) begin
      chk("phase", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, rti, bus.rsp_valid}), 64'(exp_phase(c, RTI)));
      chk("ir_in", 64'(ir_in), 64'(ir));
      chk("tdi", 64'(tdi), 64'((c >= 3 && c < 3 + DR) ? dr[c-3] : 1'b0));
      if (c == 3 + DR) chk("slave_sr_at_udr", 64'(sr), 64'(dr));
      if (c < 4 + DR + RTI) tick();
    end
    chk("rsp_dr", 64'(bus.rsp_dr), 64'(pre));
    chk("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(iru));
    chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'(1'b0));
  endtask

  task automatic finish_rsp(input int stall, input logic [DR-1:0] pre);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 64'(bus.rsp_valid), 64'(1'b1));
      chk("stall_dr", 64'(bus.rsp_dr), 64'(pre));
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("back_idle", 64'({bus.cmd_ready, bus.rsp_valid}), 64'(2'b10));
  endtask

  initial begin : main
    logic [DR-1:0] d, p, d2, p2;
    logic [1:0]    ir;
    int            first, udr_at;
    logic          rti_seen, rv_seen;

    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;  bus.cmd_ir = '0;  bus.cmd_dr = '0;  bus.rsp_ready = 1'b0;
    bus2.cmd_valid = 1'b0; bus2.cmd_ir = '0; bus2.cmd_dr = '0; bus2.rsp_ready = 1'b0;
    sl_load = 1'b0; sl_val = '0;
    irv_uir = 2'b10; irv_post = 2'b01;
    repeat (3) tick();

    chk("rst_ready_valid", 64'({bus.cmd_ready, bus.rsp_valid}), 64'(2'b10));
    chk("rst_rsp_dr", 64'(bus.rsp_dr), 64'(0));
    chk("rst_rsp_ir", 64'(bus.rsp_ir_out), 64'(0));
    chk("rst_ir_in_tdi", 64'({ir_in, tdi}), 64'(0));
    chk("rst_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, rti}), 64'(0));
    reset_n = 1'b1;
    tick();

    // Loopback with the documented patterns; ir_out is 2'b10 only during UIR.
    p = 38'h2A_5A5A_5A5A;
    d = 38'h15_1234_5678;
    start_cmd(IR_OCIMEM, d, p);
    run_seq(IR_OCIMEM, d, p, 2'b10);
    finish_rsp(0, p);

    // Backpressure: 10 stalled RESP cycles with a competing command pending.
    p  = 38'h3F_0000_FFFF; d  = 38'h01_DEAD_BEEF;
    p2 = 38'h00_C0FF_EE11; d2 = 38'h2B_0F0F_1234;
    start_cmd(IR_BREAK, d, p);
    run_seq(IR_BREAK, d, p, 2'b10);
    bus.cmd_valid = 1'b1; bus.cmd_ir = IR_TRACEMEM; bus.cmd_dr = d2;
    sl_load = 1'b1; sl_val = p2;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(bus.rsp_valid), 64'(1'b1));
      chk("bp_dr", 64'(bus.rsp_dr), 64'(p));
      chk("bp_not_accepted", 64'({bus.cmd_ready, vs_uir}), 64'(2'b00));
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_idle", 64'({bus.cmd_ready, bus.rsp_valid}), 64'(2'b10));
    tick();
    bus.cmd_valid = 1'b0;
    sl_load = 1'b0;
    run_seq(IR_TRACEMEM, d2, p2, 2'b10);
    finish_rsp(0, p2);

    // Randomized accesses against the slave-chain model.
    for (int n = 0; n < 6; n++) begin
      ir       = 2'($urandom_range(0, 3));
      d        = DR'({$urandom(), $urandom()});
      p        = DR'({$urandom(), $urandom()});
      irv_uir  = 2'($urandom_range(0, 3));
      irv_post = ~irv_uir;
      start_cmd(ir, d, p);
      run_seq(ir, d, p, irv_uir);
      finish_rsp(int'($urandom_range(0, 3)), p);
    end

    // Reset asserted for one cycle at c20 (mid-SDR) aborts the access.
    start_cmd(IR_TRACECAPTURE, 38'h12_3456_789A, 38'h0A_AAAA_5555);
    repeat (19) tick();
    chk("c20_in_sdr", 64'(vs_sdr), 64'(1'b1));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("abort_strobes", 64'({vs_uir, vs_cdr, vs_sdr, vs_udr, rti, tdi}), 64'(0));
    chk("abort_ready", 64'({bus.cmd_ready, bus.rsp_valid}), 64'(2'b10));
    rv_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.rsp_valid) rv_seen = 1'b1;
      tick();
    end
    chk("abort_no_rsp", 64'(rv_seen), 64'(1'b0));

    // RTI_CYCLES=0 build: UDR at c41 goes straight to RESP at c42.
    d = DR'({$urandom(), $urandom()});
    bus2.cmd_valid = 1'b1; bus2.cmd_ir = IR_BREAK; bus2.cmd_dr = d;
    tick();
    bus2.cmd_valid = 1'b0;
    first = 0; udr_at = 0; rti_seen = 1'b0;
    for (int c = 1; c <= 60 && first == 0; c++) begin
      if (vs_udr2) udr_at = c;
      if (rti2) rti_seen = 1'b1;
      if (c == 1) chk("r0_uir_ir", 64'({vs_uir2, ir_in2}), 64'({1'b1, IR_BREAK}));
      if (c == 2) chk("r0_cdr", 64'(vs_cdr2), 64'(1'b1));
      if (c == 3) chk("r0_sdr_tdi", 64'({vs_sdr2, tdi2}), 64'({1'b1, d[0]}));
      if (bus2.rsp_valid) first = c;
      else tick();
    end
    chk("r0_rsp_cycle", 64'(first), 64'(42));
    chk("r0_udr_cycle", 64'(udr_at), 64'(41));
    chk("r0_no_rti", 64'(rti_seen), 64'(1'b0));
    chk("r0_rsp_dr", 64'(bus2.rsp_dr), 64'({DR{1'b1}}));
    chk("r0_rsp_ir", 64'(bus2.rsp_ir_out), 64'(2'b11));
    bus2.rsp_ready = 1'b1;
    tick();
    bus2.rsp_ready = 1'b0;
    chk("r0_idle", 64'({bus2.cmd_ready, bus2.rsp_valid}), 64'(2'b10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
